// File: rtl/seg7_capture.sv
// seg7_capture: reads back a multiplexed active-low 7-segment bus,
// filters each digit for stability and decodes it into a register bank.
//
// Ports:
//   iClk, iRst_n  clock (rising edge) and asynchronous active-low reset
//   iSeg          segment bus g..a, active-low (0 = lit)
//   iDigEn        one-hot digit enables (zero allowed)
//   oDigits       decoded values, digit k at [4k+3:4k]
//   oValid        digit k holds a committed legal decode
//   oUpdate       pulse: some oDigits/oValid bit changed this cycle
//   oErr          pulse: illegal pattern committed or multi-hot enables
module seg7_capture #(
   parameter int NDIG   = 4,
   parameter int STABLE = 4
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic [6:0]        iSeg,
   input  logic [NDIG-1:0]   iDigEn,
   output logic [4*NDIG-1:0] oDigits,
   output logic [NDIG-1:0]   oValid,
   output logic              oUpdate,
   output logic              oErr
);

   typedef enum logic [1:0] {
      IDLE,
      FILTER,
      HOLD
   } state_t;

   localparam logic [3:0] STABLE_C = 4'(STABLE);

   state_t            state;
   state_t            nState;
   logic [6:0]        sSeg;
   logic [NDIG-1:0]   sEn;
   logic [6:0]        latSeg;
   logic [6:0]        nLatSeg;
   logic [NDIG-1:0]   latEn;
   logic [NDIG-1:0]   nLatEn;
   logic [3:0]        count;
   logic [3:0]        nCount;
   logic [4:0]        cntInc;
   logic              enZero;
   logic              enOne;
   logic              enMulti;
   logic              same;
   logic              commit;
   logic              multiErr;
   logic              badCommit;
   logic [4*NDIG-1:0] nDigits;
   logic [NDIG-1:0]   nValid;
   logic              decLegal;
   logic              decBlank;
   logic [3:0]        decVal;

   // Input stage: every decision uses the registered bus.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         sSeg <= '0;
         sEn  <= '0;
      end else begin
         sSeg <= iSeg;
         sEn  <= iDigEn;
      end
   end

   always_comb begin
      enZero  = (sEn == '0);
      enOne   = $onehot(sEn);
      enMulti = !enZero && !enOne;
      same    = (sEn == latEn) && (sSeg == latSeg);
      cntInc  = {1'b0, count} + 5'd1;
   end

   // State register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state  <= IDLE;
         latSeg <= '0;
         latEn  <= '0;
         count  <= '0;
      end else begin
         state  <= nState;
         latSeg <= nLatSeg;
         latEn  <= nLatEn;
         count  <= nCount;
      end
   end

   // Next-state logic. HOLD with a changed input behaves like IDLE.
   always_comb begin
      nState   = state;
      nLatSeg  = latSeg;
      nLatEn   = latEn;
      nCount   = count;
      commit   = 1'b0;
      multiErr = 1'b0;
      if (state == FILTER && same) begin
         if (cntInc >= {1'b0, STABLE_C}) begin
            nCount = STABLE_C;
            nState = HOLD;
            commit = 1'b1;
         end else begin
            nCount = cntInc[3:0];
         end
      end else if (state == HOLD && same) begin
         nState = HOLD;
      end else begin
         nLatSeg = sSeg;
         nLatEn  = sEn;
         if (enOne) begin
            nCount = 4'd1;
            if (STABLE_C == 4'd1) begin
               nState = HOLD;
               commit = 1'b1;
            end else begin
               nState = FILTER;
            end
         end else begin
            nState   = IDLE;
            nCount   = '0;
            multiErr = enMulti;
         end
      end
   end

   // Pattern decoder; at commit time sSeg is the committed pattern.
   always_comb begin
      decLegal = 1'b1;
      decBlank = 1'b0;
      decVal   = 4'd0;
      unique case (sSeg)
         7'h40: decVal = 4'd0;
         7'h79: decVal = 4'd1;
         7'h24: decVal = 4'd2;
         7'h30: decVal = 4'd3;
         7'h19: decVal = 4'd4;
         7'h12: decVal = 4'd5;
         7'h02: decVal = 4'd6;
         7'h78: decVal = 4'd7;
         7'h00: decVal = 4'd8;
         7'h10: decVal = 4'd9;
         7'h7F: begin
            decLegal = 1'b0;
            decBlank = 1'b1;
         end
         default: decLegal = 1'b0;
      endcase
   end

   // Output logic: next register-bank contents for a commit.
   always_comb begin
      nDigits   = oDigits;
      nValid    = oValid;
      badCommit = 1'b0;
      if (commit) begin
         for (int k = 0; k < NDIG; k++) begin
            if (sEn[k]) begin
               if (decLegal) begin
                  nDigits[4*k +: 4] = decVal;
                  nValid[k]         = 1'b1;
               end else begin
                  nValid[k] = 1'b0;
                  badCommit = !decBlank;
               end
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oDigits <= '0;
         oValid  <= '0;
         oUpdate <= 1'b0;
         oErr    <= 1'b0;
      end else begin
         oDigits <= nDigits;
         oValid  <= nValid;
         oUpdate <= (nDigits != oDigits) || (nValid != oValid);
         oErr    <= multiErr || badCommit;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed vectors for seg7_capture
// (NDIG=4, STABLE=4) with hand-computed expectations.
module tb_seg7_capture;

   logic        iClk;
   logic        iRst_n;
   logic [6:0]  iSeg;
   logic [3:0]  iDigEn;
   logic [15:0] oDigits;
   logic [3:0]  oValid;
   logic        oUpdate;
   logic        oErr;

   int nVec;
   int nBad;
   int updCnt;
   int errCnt;

   seg7_capture #(.NDIG(4), .STABLE(4)) dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iSeg    (iSeg),
      .iDigEn  (iDigEn),
      .oDigits (oDigits),
      .oValid  (oValid),
      .oUpdate (oUpdate),
      .oErr    (oErr)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic checkVal(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n cycles, sampling 1 time unit after each edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
         if (oUpdate) updCnt++;
         if (oErr) errCnt++;
      end
   endtask

   task automatic clrCnt();
      updCnt = 0;
      errCnt = 0;
   endtask

   task automatic drive(input logic [3:0] en, input logic [6:0] seg,
                        input int n);
      iDigEn = en;
      iSeg   = seg;
      tick(n);
   endtask

   initial begin
      nVec   = 0;
      nBad   = 0;
      iRst_n = 1'b0;
      iSeg   = 7'h7F;
      iDigEn = 4'b0000;
      clrCnt();
      tick(3);
      checkVal("rst_digits", {16'h0, oDigits}, 32'h0);
      checkVal("rst_valid", {28'h0, oValid}, 32'h0);
      checkVal("rst_pulses", {30'h0, oUpdate, oErr}, 32'h0);
      #2 iRst_n = 1'b1;
      tick(2);

      // 1: single digit, latency and single update
      clrCnt();
      iDigEn = 4'b0001;
      iSeg   = 7'h24;
      tick(4);
      checkVal("t1_before", {28'h0, oValid}, 32'h0);
      tick(1);
      checkVal("t1_commit_valid", {28'h0, oValid}, 32'h1);
      checkVal("t1_commit_upd", {31'h0, oUpdate}, 32'h1);
      tick(1);
      checkVal("t1_digit", {16'h0, oDigits}, 32'h0002);
      checkVal("t1_upd_cnt", updCnt, 32'd1);
      checkVal("t1_err_cnt", errCnt, 32'd0);

      // 2: scan four digits twice
      clrCnt();
      drive(4'b0001, 7'h30, 5);
      drive(4'b0010, 7'h19, 5);
      drive(4'b0100, 7'h12, 5);
      drive(4'b1000, 7'h40, 5);
      checkVal("t2_pass1_upd", updCnt, 32'd4);
      checkVal("t2_pass1_dig", {16'h0, oDigits}, 32'h0543);
      drive(4'b0001, 7'h30, 5);
      drive(4'b0010, 7'h19, 5);
      drive(4'b0100, 7'h12, 5);
      drive(4'b1000, 7'h40, 5);
      checkVal("t2_digits", {16'h0, oDigits}, 32'h0543);
      checkVal("t2_valid", {28'h0, oValid}, 32'hF);
      checkVal("t2_upd_cnt", updCnt, 32'd4);
      checkVal("t2_err_cnt", errCnt, 32'd0);

      // reset before unstable test
      iDigEn = 4'b0000;
      #2 iRst_n = 1'b0;
      #1;
      checkVal("rst2_digits", {16'h0, oDigits}, 32'h0);
      checkVal("rst2_valid", {28'h0, oValid}, 32'h0);
      #2 iRst_n = 1'b1;
      tick(2);

      // 3: toggling pattern never commits
      clrCnt();
      for (int i = 0; i < 10; i++)
         drive(4'b0010, (i % 2 == 0) ? 7'h79 : 7'h24, 2);
      drive(4'b0000, 7'h7F, 3);
      checkVal("t3_valid", {28'h0, oValid}, 32'h0);
      checkVal("t3_upd_cnt", updCnt, 32'd0);

      // 4: digit2 = 7, then blank, then illegal
      drive(4'b0100, 7'h78, 5);
      checkVal("t4_valid7", {28'h0, oValid}, 32'h4);
      checkVal("t4_digit7", {16'h0, oDigits}, 32'h0700);
      clrCnt();
      drive(4'b0100, 7'h7F, 5);
      checkVal("t4_blank_valid", {28'h0, oValid}, 32'h0);
      checkVal("t4_blank_digit", {16'h0, oDigits}, 32'h0700);
      checkVal("t4_blank_upd", updCnt, 32'd1);
      checkVal("t4_blank_err", errCnt, 32'd0);
      clrCnt();
      drive(4'b0100, 7'h55, 6);
      checkVal("t4_ill_err", errCnt, 32'd1);
      checkVal("t4_ill_upd", updCnt, 32'd0);

      // 5: multi-hot enables
      clrCnt();
      drive(4'b0110, 7'h24, 2);
      checkVal("t5_err_2cyc", errCnt, 32'd1);
      drive(4'b0110, 7'h24, 1);
      drive(4'b0000, 7'h7F, 4);
      checkVal("t5_digits", {16'h0, oDigits}, 32'h0700);
      checkVal("t5_upd_cnt", updCnt, 32'd0);

      // 6: reset mid-filter
      drive(4'b0001, 7'h00, 5);
      checkVal("t6_pre_valid", {28'h0, oValid}, 32'h1);
      drive(4'b1000, 7'h12, 3);
      #2 iRst_n = 1'b0;
      #1;
      checkVal("t6_rst_digits", {16'h0, oDigits}, 32'h0);
      checkVal("t6_rst_valid", {28'h0, oValid}, 32'h0);
      checkVal("t6_rst_pulses", {30'h0, oUpdate, oErr}, 32'h0);
      #2 iRst_n = 1'b1;
      clrCnt();
      tick(4);
      checkVal("t6_window", {28'h0, oValid}, 32'h0);
      tick(1);
      checkVal("t6_commit_valid", {28'h0, oValid}, 32'h8);
      checkVal("t6_commit_digit", {16'h0, oDigits}, 32'h5000);
      checkVal("t6_upd_cnt", updCnt, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
